// File: rtl/encoder16x4_drain.sv
// rtl/encoder16x4_drain.sv - drains a request vector as a stream of set-bit indices, LSB first
// Optional ENC_POPCOUNT_EN adds out_count, the number of indices still to be emitted.
module encoder16x4_drain #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
`ifdef ENC_POPCOUNT_EN
  output logic [IDXW:0]    out_count,
`endif
  output logic             busy
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic [IDXW-1:0]  low_idx;
  logic             single_bit;
  logic             capture, pop;

  // Scan from the MSB down so the last hit wins, leaving the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IDXW'(i);
    end
  end

  assign single_bit = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state == DRAIN);
  assign out_valid = (state == DRAIN);
  assign out_idx   = low_idx;
  assign out_last  = (state == DRAIN) && single_bit;

  assign capture = in_valid && in_ready;
  assign pop     = out_valid && out_ready;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      IDLE: begin
        // An all-zero vector is accepted and silently dropped.
        if (capture && (in_vec != '0)) begin
          pending_next = in_vec;
          state_next   = DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          pending_next = pending & (pending - WIDTH'(1));
          if (out_last) state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

`ifdef ENC_POPCOUNT_EN
  logic [IDXW:0] vec_count;
  logic [IDXW:0] count_q;

  always_comb begin
    vec_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vec_count = vec_count + (IDXW + 1)'(in_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (capture) begin
      count_q <= vec_count;
    end else if (pop) begin
      count_q <= count_q - (IDXW + 1)'(1);
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_encoder16x4_drain.sv
// tb/tb_encoder16x4_drain.sv - directed-vector bench for encoder16x4_drain
// Build with ENC_POPCOUNT_EN defined to also cover out_count.
module tb_encoder16x4_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        busy;
`ifdef ENC_POPCOUNT_EN
  logic [4:0]  out_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  encoder16x4_drain #(.WIDTH(16), .IDXW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
`ifdef ENC_POPCOUNT_EN
    .out_count (out_count),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag, input int expected);
`ifdef ENC_POPCOUNT_EN
    check(tag, 32'(out_count), 32'(expected));
`endif
  endtask

  // Present a vector for exactly one capture edge, then withdraw it.
  task automatic capture_vec(input logic [15:0] vec);
    in_vec   = vec;
    in_valid = 1'b1;
    check("in_ready_before_capture", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = 16'h0000;
    out_ready = 1'b0;
    step();
    step();

    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check_count("rst_count", 0);

    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Zero vector: consumed, nothing emitted.
    capture_vec(16'h0000);
    check("zero_out_valid", 32'(out_valid), 32'd0);
    check("zero_busy",      32'(busy),      32'd0);
    check("zero_in_ready",  32'(in_ready),  32'd1);
    step();
    check("zero_out_valid_2", 32'(out_valid), 32'd0);

    // 16'h8421 -> 0, 5, 10, 15
    out_ready = 1'b1;
    capture_vec(16'h8421);
    check("v8421_in_ready_drain", 32'(in_ready), 32'd0);
    check("v8421_busy",           32'(busy),     32'd1);
    begin
      logic [3:0] exp_idx [4];
      exp_idx[0] = 4'd0; exp_idx[1] = 4'd5; exp_idx[2] = 4'd10; exp_idx[3] = 4'd15;
      for (int k = 0; k < 4; k++) begin
        check("v8421_valid", 32'(out_valid), 32'd1);
        check("v8421_idx",   32'(out_idx),   32'(exp_idx[k]));
        check("v8421_last",  32'(out_last),  (k == 3) ? 32'd1 : 32'd0);
        check("v8421_ready", 32'(in_ready),  32'd0);
        check_count("v8421_count", 4 - k);
        step();
      end
    end
    check("v8421_done_in_ready",  32'(in_ready),  32'd1);
    check("v8421_done_out_valid", 32'(out_valid), 32'd0);
    check("v8421_done_busy",      32'(busy),      32'd0);
    check_count("v8421_done_count", 0);

    // All ones: 0..15 back-to-back.
    capture_vec(16'hFFFF);
    for (int k = 0; k < 16; k++) begin
      check("vffff_valid", 32'(out_valid), 32'd1);
      check("vffff_idx",   32'(out_idx),   32'(k));
      check("vffff_last",  32'(out_last),  (k == 15) ? 32'd1 : 32'd0);
      check_count("vffff_count", 16 - k);
      step();
    end
    check("vffff_done_in_ready", 32'(in_ready), 32'd1);

    // 16'h0006 with a 3-cycle stall and a competing vector during DRAIN.
    out_ready = 1'b0;
    capture_vec(16'h0006);
    in_vec   = 16'h0100;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx",   32'(out_idx),   32'd1);
      check("stall_last",  32'(out_last),  32'd0);
      check("stall_ready", 32'(in_ready),  32'd0);
      check_count("stall_count", 2);
      step();
    end
    out_ready = 1'b1;
    check("v0006_idx0", 32'(out_idx), 32'd1);
    step();
    check("v0006_idx1",  32'(out_idx),  32'd2);
    check("v0006_last1", 32'(out_last), 32'd1);
    check("v0006_ready", 32'(in_ready), 32'd0);
    check_count("v0006_count1", 1);
    in_valid = 1'b0;
    step();
    check("v0006_done_valid", 32'(out_valid), 32'd0);
    check("v0006_done_ready", 32'(in_ready),  32'd1);
    step();
    check("v0100_not_captured", 32'(busy), 32'd0);

    // Single bit near the top.
    capture_vec(16'h1000);
    check("v1000_valid", 32'(out_valid), 32'd1);
    check("v1000_idx",   32'(out_idx),   32'd12);
    check("v1000_last",  32'(out_last),  32'd1);
    check_count("v1000_count", 1);
    step();
    check("v1000_done_ready", 32'(in_ready), 32'd1);

    // MSB only.
    capture_vec(16'h8000);
    check("v8000_idx",  32'(out_idx),  32'd15);
    check("v8000_last", 32'(out_last), 32'd1);
    step();
    check("v8000_done_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of draining 16'h00F0.
    capture_vec(16'h00F0);
    check("v00f0_idx0", 32'(out_idx), 32'd4);
    check_count("v00f0_count0", 4);
    step();
    check("v00f0_idx1", 32'(out_idx), 32'd5);
    rst = 1'b1;
    #1;
    check("midrst_in_ready_comb", 32'(in_ready), 32'd0);
    step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_out_idx",   32'(out_idx),   32'd0);
    check_count("midrst_count", 0);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", 32'(in_ready), 32'd1);
    step();
    check("midrst_idle_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder16x4_drain.md
Name: encoder16x4_drain

Overview:
- Sequential priority encoder, the inverse of the team's binary-to-one-hot decoders.
- Accepts a WIDTH-bit request vector over a valid/ready handshake.
- Emits the binary index of every set bit, one per handshake, LSB first.
- Sits between status/interrupt-style bit vectors and index-driven logic, e.g. it feeds decoder3x8/decoder4x16-style consumers.

Parameters:
WIDTH, 16, input vector width; must be a power of two, >= 2
IDXW, 4, index width; must equal log2(WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_vec is valid
in_ready  output  1  block can capture a vector
in_vec  input  WIDTH  request vector to encode
out_valid  output  1  out_idx is valid
out_ready  input  1  downstream accepts out_idx
out_idx  output  IDXW  binary index of lowest pending set bit
out_last  output  1  out_idx is the final index of the current vector
busy  output  1  a vector is being drained

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- State: FSM {IDLE, DRAIN} plus pending register (WIDTH bits).
- Reset (rst=1 at an edge): state=IDLE, pending=0. Consequences:
  - out_valid=0, out_idx=0, out_last=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst deasserts.
- in_ready = (state==IDLE) & ~rst. busy = (state==DRAIN).
- Outputs depend only on registered state; there is no combinational path from in_* or out_ready to any output.
- IDLE:
  - Capture occurs when in_valid & in_ready.
  - Captured in_vec != 0: pending<=in_vec, go to DRAIN.
  - Captured in_vec == 0: vector is consumed and dropped, no output produced, stay IDLE.
- DRAIN:
  - out_valid=1.
  - out_idx = position of the lowest set bit of pending.
  - out_last = 1 iff pending has exactly one bit set.
  - Handshake when out_valid & out_ready: clear that lowest bit in pending.
  - If out_last was 1 at the handshake, go to IDLE. pending becomes 0.
  - No handshake: out_idx, out_last and pending hold stable. Downstream may stall indefinitely.
- Latency: vector captured at edge N gives out_valid=1 in the cycle after edge N.
- Throughput: a vector with k set bits needs k output handshakes, then 1 IDLE cycle before the next capture. in_ready is 0 throughout DRAIN, including the last-pop cycle.
- Boundaries:
  - in_vec all ones emits 0..WIDTH-1 in order; out_last only on WIDTH-1.
  - Single bit at MSB emits index WIDTH-1 with out_last=1.
  - in_valid held in DRAIN is ignored, not captured. in_vec may change freely while in_ready=0.
- Reset mid-DRAIN: pending cleared, remaining indices discarded, out_valid=0 next cycle.
- Index arithmetic is unsigned, IDXW bits. No wrap is possible since WIDTH=2^IDXW.

Optional Feature:
- Macro ENC_POPCOUNT_EN.
- Defined: adds output port out_count (IDXW+1 bits).
  - out_count = number of set bits remaining in pending, including the current out_idx.
  - It is 0 in IDLE and during reset, and decrements by 1 on each output handshake.
- Not defined: port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_vec=16'h0000 with in_valid=1 -> in_ready=1, captured, out_valid stays 0, busy stays 0, next in_ready=1.
- in_vec=16'h8421, out_ready=1 -> out_idx 0,5,10,15 on consecutive cycles; out_last=1 only with 15; in_ready=1 the cycle after 15 is popped.
- in_vec=16'hFFFF, out_ready=1 -> 16 outputs 0..15 back-to-back, no gaps; with ENC_POPCOUNT_EN, out_count goes 16 down to 1.
- in_vec=16'h0006, out_ready low 3 cycles then high -> out_idx=1 held stable 3 cycles, then 1 and 2 emitted; a second in_vec presented during DRAIN is not captured.
- in_vec=16'h1000 -> out_valid one cycle after capture, out_idx=12, out_last=1.
- in_vec=16'h00F0, rst=1 after first pop (idx 4) -> next cycle out_valid=0, busy=0, out_count=0; after rst release in_ready=1.
